// File: rtl/ahb_to_fpga_sram.sv
// rtl/ahb_to_fpga_sram.sv - AHB-Lite slave bridge to FPGA block-RAM SRAM with a one-entry write buffer
// Define AHB_TO_FPGA_SRAM_ALIGN_CHK_EN to answer unaligned transfers with a two-cycle ERROR.
module ahb_to_fpga_sram #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [AW+1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWREN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);
  logic          accept;
  logic          unaligned;
  logic          rd_acc;
  logic          wr_acc;
  logic [3:0]    mask;
  logic [AW-1:0] waddr;
  logic          unused_htrans0;

  logic          rd_dp_q;
  logic          wr_dp_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    wr_mask_q;
  logic          buf_pend_q;
  logic          buf_pend_d;
  logic [AW-1:0] buf_addr_q;
  logic [3:0]    buf_mask_q;
  logic [31:0]   buf_data_q;

  assign unused_htrans0 = HTRANS[0];
  assign accept = HSEL & HREADY & HTRANS[1];
  assign waddr  = HADDR[AW+1:2];

  always_comb begin
    mask = 4'b1111;
    case (HSIZE)
      3'd0:    mask = 4'b0001 << HADDR[1:0];
      3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

`ifdef AHB_TO_FPGA_SRAM_ALIGN_CHK_EN
  typedef enum logic [1:0] {ERR_IDLE, ERR_FIRST, ERR_SECOND} err_state_e;
  err_state_e err_q;
  logic       hreadyout_q;
  logic       hresp_q;

  assign unaligned = ((HSIZE == 3'd1) & HADDR[0]) |
                     ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_q       <= ERR_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (err_q)
        ERR_FIRST: begin
          err_q       <= ERR_SECOND;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (accept & unaligned) begin
            err_q       <= ERR_FIRST;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            err_q       <= ERR_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
`else
  assign unaligned = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  assign rd_acc = accept & ~HWRITE & ~unaligned;
  assign wr_acc = accept &  HWRITE & ~unaligned;

  // A read address phase owns the SRAM port; otherwise a pending buffer drains.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWREN  = 4'b0000;
    SRAMADDR  = '0;
    SRAMWDATA = 32'h0;
    if (!HRESET) begin
      if (rd_acc) begin
        SRAMCS   = 1'b1;
        SRAMADDR = waddr;
      end else if (buf_pend_q) begin
        SRAMCS    = 1'b1;
        SRAMADDR  = buf_addr_q;
        SRAMWDATA = buf_data_q;
        SRAMWREN  = buf_mask_q;
      end
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (rd_dp_q) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (buf_pend_q && (buf_addr_q == rd_addr_q) && buf_mask_q[i]) ?
                           buf_data_q[8*i +: 8] : SRAMRDATA[8*i +: 8];
      end
    end
  end

  // Reload wins over drain so a back-to-back write keeps the buffer pending.
  always_comb begin
    buf_pend_d = buf_pend_q;
    if (wr_dp_q) begin
      buf_pend_d = 1'b1;
    end else if (buf_pend_q && !rd_acc) begin
      buf_pend_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rd_dp_q    <= 1'b0;
      wr_dp_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_mask_q  <= 4'b0000;
      buf_pend_q <= 1'b0;
      buf_addr_q <= '0;
      buf_mask_q <= 4'b0000;
      buf_data_q <= 32'h0;
    end else begin
      rd_dp_q    <= rd_acc;
      wr_dp_q    <= wr_acc;
      buf_pend_q <= buf_pend_d;
      if (rd_acc) begin
        rd_addr_q <= waddr;
      end
      if (wr_acc) begin
        wr_addr_q <= waddr;
        wr_mask_q <= mask;
      end
      if (wr_dp_q) begin
        buf_addr_q <= wr_addr_q;
        buf_mask_q <= wr_mask_q;
        buf_data_q <= HWDATA;
      end
    end
  end
endmodule

// File: tb/tb_ahb_to_fpga_sram.sv
// tb/tb_ahb_to_fpga_sram.sv - scoreboard bench for ahb_to_fpga_sram
module tb_ahb_to_fpga_sram;
  localparam int AW = 16;

  logic          HCLK;
  logic          HRESET;
  logic          HSEL;
  logic [AW+1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWREN;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA;

  ahb_to_fpga_sram #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMADDR(SRAMADDR),
    .SRAMWDATA(SRAMWDATA), .SRAMWREN(SRAMWREN), .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    m;
    logic [31:0]   d;
  } wr_t;

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] nxt_wdata;
  bit          rd_dp;
  int          checks;
  int          errors;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWREN == 4'h0) SRAMRDATA <= mem[SRAMADDR];
      else for (int i = 0; i < 4; i++)
        if (SRAMWREN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] bmask(input logic [2:0] sz, input logic [1:0] lo);
    logic [3:0] one;
    one = 4'b0001;
    if (sz == 3'd0) return one << lo;
    if (sz == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic monitor();
    wr_t e;
    if (SRAMWREN != 4'h0) begin
      if (exp_wr_q.size() == 0) chk("unexp_wren", 32'(SRAMWREN), 32'h0);
      else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(SRAMADDR), 32'(e.a));
        chk("wr_mask", 32'(SRAMWREN), 32'(e.m));
        chk("wr_data", SRAMWDATA, e.d);
        chk("wr_cs", 32'(SRAMCS), 32'd1);
      end
    end
    if (rd_dp) begin
      if (exp_rd_q.size() == 0) chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd1);
      else chk("hrdata", HRDATA, exp_rd_q.pop_front());
    end else begin
      chk("hrdata_idle", HRDATA, 32'h0);
    end
    chk("hreadyout", 32'(HREADYOUT), 32'd1);
    chk("hresp", 32'(HRESP), 32'd0);
  endtask

  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [AW+1:0] addr, input logic [2:0] sz,
                      input logic [31:0] data, input bit track);
    logic [3:0]    m;
    logic [AW-1:0] wa;
    bit            rd_next;
    @(negedge HCLK);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = sz; HWDATA = nxt_wdata;
    #1;
    monitor();
    nxt_wdata = 32'h0;
    rd_next   = 1'b0;
    m  = bmask(sz, addr[1:0]);
    wa = addr[AW+1:2];
    if (sel && trans[1] && HREADY) begin
      if (wr) begin
        nxt_wdata = data;
        if (track) begin
          exp_wr_q.push_back('{a: wa, m: m, d: data});
          for (int i = 0; i < 4; i++) if (m[i]) ref_mem[wa][8*i +: 8] = data[8*i +: 8];
        end
      end else begin
        chk("rd_cs", 32'(SRAMCS), 32'd1);
        chk("rd_addr", 32'(SRAMADDR), 32'(wa));
        chk("rd_no_wren", 32'(SRAMWREN), 32'h0);
        if (track) begin
          exp_rd_q.push_back(ref_mem[wa]);
          rd_next = 1'b1;
        end
      end
    end
    rd_dp = rd_next;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, '0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [AW+1:0] a, input logic [2:0] sz, input logic [31:0] d);
    step(1'b1, 2'b10, 1'b1, a, sz, d, 1'b1);
  endtask

  task automatic rd(input logic [AW+1:0] a);
    step(1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0, 1'b1);
  endtask

  initial begin
    int            op;
    int            last1;
    int            last2;
    logic [2:0]    sz;
    logic [AW+1:0] a;
    checks = 0; errors = 0; rd_dp = 1'b0; nxt_wdata = 32'h0; SRAMRDATA = 32'h0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HSIZE = 3'd0; HWDATA = 32'h0; HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_cs", 32'(SRAMCS), 32'd0);
    chk("rst_wren", 32'(SRAMWREN), 32'd0);
    chk("rst_addr", 32'(SRAMADDR), 32'd0);
    chk("rst_wdata", SRAMWDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    // word write then drain one cycle after the data phase
    wr('h10, 3'd2, 32'h12345678);
    idle();
    chk("t1_no_early_wren", 32'(SRAMWREN), 32'd0);
    idle();
    chk("t1_wren", 32'(SRAMWREN), 32'hF);
    chk("t1_addr", 32'(SRAMADDR), 32'h4);
    chk("t1_wdata", SRAMWDATA, 32'h12345678);
    rd('h10);
    idle();
    chk("t1_rdata", HRDATA, 32'h12345678);

    // byte write with back-to-back read merges the buffer
    wr('h13, 3'd0, 32'hAAAAAAAA);
    rd('h10);
    idle();
    chk("t2_merge", HRDATA, 32'hAA345678);
    chk("t2_wren", 32'(SRAMWREN), 32'h8);

    // A drains in B's data phase; B waits behind three reads
    wr('h40, 3'd2, 32'h11111111);
    wr('h44, 3'd2, 32'h22222222);
    idle();
    chk("t3_a_wren", 32'(SRAMWREN), 32'hF);
    chk("t3_a_addr", 32'(SRAMADDR), 32'h10);
    rd('h44);
    rd('h40);
    rd('h44);
    idle();
    chk("t3_b_addr", 32'(SRAMADDR), 32'h11);
    chk("t3_b_wdata", SRAMWDATA, 32'h22222222);
    chk("t3_last_rd", HRDATA, 32'h22222222);

    // half-word writes to both halves
    wr('h22, 3'd1, 32'hBEEFBEEF);
    wr('h20, 3'd1, 32'hCAFECAFE);
    idle();
    chk("t4_hi_wren", 32'(SRAMWREN), 32'hC);
    idle();
    chk("t4_lo_wren", 32'(SRAMWREN), 32'h3);
    rd('h20);
    idle();
    chk("t4_rdata", HRDATA, 32'hBEEFCAFE);

    // reset while a write is buffered and a read data phase is active
    step(1'b1, 2'b10, 1'b1, 'h50, 3'd2, 32'hDEADBEEF, 1'b0);
    step(1'b1, 2'b10, 1'b0, 'h10, 3'd2, 32'h0, 1'b0);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0; HRESET = 1'b1;
    #1;
    chk("t5_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("t5_hrdata", HRDATA, 32'h0);
    chk("t5_wren", 32'(SRAMWREN), 32'd0);
    chk("t5_cs", 32'(SRAMCS), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0; nxt_wdata = 32'h0; rd_dp = 1'b0;
    repeat (3) idle();
    rd('h50);
    idle();

    // unaligned word read
    wr('h0, 3'd2, 32'hA5A50F0F);
    idle();
    idle();
`ifdef AHB_TO_FPGA_SRAM_ALIGN_CHK_EN
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 'h2; HSIZE = 3'd2; HWDATA = 32'h0;
    #1;
    chk("t6_cs", 32'(SRAMCS), 32'd0);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b0;
    #1;
    chk("t6_c1_ready", 32'(HREADYOUT), 32'd0);
    chk("t6_c1_resp", 32'(HRESP), 32'd1);
    chk("t6_c1_cs", 32'(SRAMCS), 32'd0);
    @(negedge HCLK);
    HREADY = 1'b1;
    #1;
    chk("t6_c2_ready", 32'(HREADYOUT), 32'd1);
    chk("t6_c2_resp", 32'(HRESP), 32'd1);
    rd_dp = 1'b0;
    idle();
`else
    rd('h2);
    idle();
    chk("t6_rdata", HRDATA, 32'hA5A50F0F);
    chk("t6_resp", 32'(HRESP), 32'd0);
`endif

    // random aligned traffic; W,W,R would clobber a buffer the read keeps from draining
    last1 = 0; last2 = 0;
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 2);
      if (op == 2 && last1 == 1 && last2 == 1) op = 0;
      sz = 3'($urandom_range(0, 2));
      a  = (AW+2)'('h400 + 4 * $urandom_range(0, 7));
      if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) a[1] = 1'($urandom_range(0, 1));
      if (op == 1) wr(a, sz, $urandom);
      else if (op == 2) rd(a);
      else step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'b0, a, sz, 32'h0, 1'b0);
      last2 = last1;
      last1 = (op == 1) ? 1 : 0;
    end
    repeat (4) idle();
    chk("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    chk("rd_q_left", 32'(exp_rd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
